// File: rtl/bitcoin_pkg.sv
// Shared definitions for the hashing datapath: memory geometry and the
// result-writer state encoding, also used by the message fetch logic.
package bitcoin_pkg;

  localparam int MEM_AW = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } writer_state_t;

  // Word address arithmetic wraps modulo 2^MEM_AW by construction.
  function automatic logic [MEM_AW-1:0] wrap_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [MEM_AW-1:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/hash_result_writer.sv
// Captures NUM_WORDS hash results and writes them to consecutive memory words,
// optionally reading each one back and recording the first mismatch.
//   state     | meaning
//   ST_IDLE   | waiting for start; mem_we low
//   ST_WRITE  | one write per cycle, word r_idx at r_base+r_idx
//   ST_VERIFY | one read per cycle, compare lags the address by one cycle
//   ST_DONE   | one-cycle done pulse, busy low
module hash_result_writer
  import bitcoin_pkg::*;
#(
  parameter int NUM_WORDS = 16,
  parameter bit VERIFY    = 1'b1,
  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] output_addr,
  input  logic [WORD_W-1:0] words [NUM_WORDS],
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IW-1:0]     err_index,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_write_data,
  input  logic [WORD_W-1:0] mem_read_data
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  writer_state_t     r_state;
  writer_state_t     w_state_nxt;
  logic [WORD_W-1:0] r_buf [NUM_WORDS];
  logic [MEM_AW-1:0] r_base;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_cmp_idx;
  logic              r_cmp_valid;
  logic              r_rd_active;
  logic              r_error;
  logic [IW-1:0]     r_err_index;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;

  logic [IW-1:0]     w_idx_inc;
  logic              w_idx_last;
  logic              w_cmp_last;
  logic              w_mismatch;
  logic              w_accept;

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_idx_last = (r_idx == LAST_IDX);
  assign w_cmp_last = r_cmp_valid && (r_cmp_idx == LAST_IDX);
  assign w_mismatch = r_cmp_valid && (mem_read_data != r_buf[r_cmp_idx]);
  assign w_accept   = (r_state == ST_IDLE) && start;

  assign mem_clk        = clk;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign error          = r_error;
  assign err_index      = r_err_index;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start)      w_state_nxt = ST_WRITE;
      ST_WRITE:  if (w_idx_last) w_state_nxt = VERIFY ? ST_VERIFY : ST_DONE;
      ST_VERIFY: if (w_cmp_last) w_state_nxt = ST_DONE;
      ST_DONE:                   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      ST_WRITE, ST_VERIFY: busy = 1'b1;
      ST_DONE:             done = 1'b1;
      default:             ;
    endcase
  end

  // The result bank is only ever read after capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !reset) r_buf <= words;
  end

  // Memory-side registers are loaded one cycle ahead so that each access is
  // presented in the cycle the state machine is in for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= '0;
      r_idx       <= '0;
      r_cmp_idx   <= '0;
      r_cmp_valid <= 1'b0;
      r_rd_active <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_cmp_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base      <= output_addr;
            r_idx       <= '0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= output_addr;
            r_mem_wdata <= words[0];
          end
        end
        ST_WRITE: begin
          if (w_idx_last) begin
            r_mem_we    <= 1'b0;
            r_idx       <= '0;
            r_rd_active <= VERIFY;
            r_mem_addr  <= r_base;
          end else begin
            r_idx       <= w_idx_inc;
            r_mem_addr  <= wrap_addr(r_base, MEM_AW'(w_idx_inc));
            r_mem_wdata <= r_buf[w_idx_inc];
          end
        end
        ST_VERIFY: begin
          if (r_rd_active) begin
            r_cmp_valid <= 1'b1;
            r_cmp_idx   <= r_idx;
            if (w_idx_last) begin
              r_rd_active <= 1'b0;
            end else begin
              r_idx      <= w_idx_inc;
              r_mem_addr <= wrap_addr(r_base, MEM_AW'(w_idx_inc));
            end
          end
          if (w_mismatch && !r_error) begin
            r_error     <= 1'b1;
            r_err_index <= r_cmp_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_result_writer.sv
// Scoreboard bench: two writers (write-only and verify) share stimulus; each
// has its own memory model and expected write/done queues checked by a monitor.
module tb_hash_result_writer;
  import bitcoin_pkg::*;

  localparam int N  = 16;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [15:0] wa;
    logic [31:0] wdat;
    int          wc;
  } wr_t;

  typedef struct {
    int          dc;
    logic        de;
    logic [IW-1:0] dix;
  } dn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] output_addr;
  logic [31:0] words [N];
  logic        stuck_en;

  logic          busy [2];
  logic          done [2];
  logic          err  [2];
  logic [IW-1:0] eix  [2];
  logic          mclk [2];
  logic          we   [2];
  logic [15:0]   ma   [2];
  logic [31:0]   wd   [2];
  logic [31:0]   rd   [2];

  logic [31:0] mem [2][65536];

  wr_t wq [2][$];
  dn_t dq [2][$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hash_result_writer #(.NUM_WORDS(N), .VERIFY(1'b0)) u_wo (
    .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .words(words),
    .busy(busy[0]), .done(done[0]), .error(err[0]), .err_index(eix[0]),
    .mem_clk(mclk[0]), .mem_we(we[0]), .mem_addr(ma[0]), .mem_write_data(wd[0]),
    .mem_read_data(rd[0])
  );

  hash_result_writer #(.NUM_WORDS(N), .VERIFY(1'b1)) u_vf (
    .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .words(words),
    .busy(busy[1]), .done(done[1]), .error(err[1]), .err_index(eix[1]),
    .mem_clk(mclk[1]), .mem_we(we[1]), .mem_addr(ma[1]), .mem_write_data(wd[1]),
    .mem_read_data(rd[1])
  );

  // Synchronous memories; reads return one cycle after the address.
  // stuck_en forces bit 0 high on readback at 0x0103 and 0x0107.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d]) mem[d][ma[d]] <= wd[d];
      rd[d] <= mem[d][ma[d]] |
               {31'd0, stuck_en && (ma[d] == 16'h0103 || ma[d] == 16'h0107)};
    end
  end

  function automatic void chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=event expected=none (cycle %0d)", nm, cyc);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d] === 1'b1) begin
        if (wq[d].size() == 0) flag($sformatf("unexpected_write_dut%0d addr=%h", d, ma[d]));
        else begin
          wr_t w;
          w = wq[d].pop_front();
          chk($sformatf("write_dut%0d{addr,data,cycle}", d),
              {ma[d], wd[d], 32'(cyc)}, {w.wa, w.wdat, 32'(w.wc)});
        end
      end
      if (done[d] === 1'b1) begin
        if (dq[d].size() == 0) flag($sformatf("unexpected_done_dut%0d", d));
        else begin
          dn_t e;
          e = dq[d].pop_front();
          chk($sformatf("done_dut%0d{cycle,error,err_index,busy}", d),
              {32'(cyc), err[d], eix[d], busy[d]}, {32'(e.dc), e.de, e.dix, 1'b0});
        end
      end
    end
  end

  // Starts a job in the next cycle and queues its expected writes and done.
  task automatic launch(input logic [15:0] base, input logic [31:0] seed,
                        input logic [31:0] step, input logic exp_err,
                        input logic [IW-1:0] exp_ix, input int nw, input bit push_done);
    int c;
    @(posedge clk); #1;
    c = cyc;
    output_addr = base;
    for (int k = 0; k < N; k++) words[k] = seed + step * 32'(k);
    start = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < nw; k++)
        wq[d].push_back('{wa: base + 16'(k), wdat: words[k], wc: c + 1 + k});
    if (push_done) begin
      dq[0].push_back('{dc: c + N + 1,     de: 1'b0,    dix: '0});
      dq[1].push_back('{dc: c + 2 * N + 2, de: exp_err, dix: exp_ix});
    end
    @(posedge clk); #1;
    start = 1'b0;
    output_addr = 16'hDEAD;
    for (int k = 0; k < N; k++) words[k] = ~words[k];
    @(negedge clk);
    chk("busy_cycle1_dut0", busy[0], 1'b1);
    chk("busy_cycle1_dut1", busy[1], 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((wq[0].size() + wq[1].size() + dq[0].size() + dq[1].size()) != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if ((wq[0].size() + wq[1].size() + dq[0].size() + dq[1].size()) != 0) begin
      flag("timeout_waiting_for_job");
      for (int d = 0; d < 2; d++) begin
        wq[d].delete();
        dq[d].delete();
      end
    end
  endtask

  task automatic check_mem(input logic [15:0] base, input logic [31:0] seed, input logic [31:0] step);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < N; k++)
        chk($sformatf("mem_dut%0d_word%0d", d, k), mem[d][base + 16'(k)], seed + step * 32'(k));
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s_dut%0d{busy,done,err,eix,we,addr,wdata,mclk}", nm, d),
          {busy[d], done[d], err[d], eix[d], we[d], ma[d], wd[d], mclk[d]}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stuck_en = 1'b0;
    output_addr = '0;
    for (int k = 0; k < N; k++) words[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Basic job, ideal memory.
    launch(16'h0100, 32'hA5A50000, 32'd1, 1'b0, '0, N, 1'b1);
    wait_idle(100);
    check_mem(16'h0100, 32'hA5A50000, 32'd1);

    // Even data so the stuck bit shows at 0x0103 and 0x0107; first is index 3.
    stuck_en = 1'b1;
    launch(16'h0100, 32'hC0DE0000, 32'd2, 1'b1, IW'(3), N, 1'b1);
    wait_idle(100);

    // Back-to-back: start in the cycle after the verify writer's done.
    launch(16'h0200, 32'h5A5A1000, 32'd3, 1'b0, '0, N, 1'b1);
    wait_idle(100);
    check_mem(16'h0200, 32'h5A5A1000, 32'd3);
    stuck_en = 1'b0;

    // Address wrap past 0xFFFF.
    launch(16'hFFFC, 32'h12345678, 32'h01010101, 1'b0, '0, N, 1'b1);
    wait_idle(100);
    check_mem(16'hFFFC, 32'h12345678, 32'h01010101);

    // A start in cycle 3 of a running job is ignored.
    launch(16'h0300, 32'h0BAD0000, 32'd5, 1'b0, '0, N, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1;
    output_addr = 16'h0400;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);
    repeat (5) @(posedge clk);

    // Reset in cycle 5: writes 0..4 only, then reset values and no done.
    launch(16'h0500, 32'hFEED0000, 32'd7, 1'b0, '0, 5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_midjob_reset");
    repeat (40) @(posedge clk);

    // Reset and start together: the start is lost.
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    output_addr = 16'h0600;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_with_start");
    repeat (25) @(posedge clk);

    @(negedge clk);
    chk("pending_writes", 32'(wq[0].size() + wq[1].size()), 32'd0);
    chk("pending_dones", 32'(dq[0].size() + dq[1].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_result_writer.md
# hash_result_writer

Write-back engine for the hashing datapath. It captures a bank of NUM_WORDS 32-bit hash results (one per nonce) and stores them as consecutive words starting at a base address in the shared single-port word memory. It can optionally read every word back and compare it, to confirm the write. It sits at the output end of the memory interface: the message fetch logic reads the block header in through this port, and this block writes results out through it.

## Interface
- NUM_WORDS, 16, number of 32-bit result words written per job (2..256)
- VERIFY, 1, 1 = read back and compare after writing; 0 = write only
- clk  in  1  system clock; also forwarded as mem_clk
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- output_addr  in  16  base word address; captured on accepted start
- words  in  NUM_WORDS x 32  unpacked array of results; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  readback mismatch seen in the last job; sticky until the next accepted start
- err_index  out  $clog2(NUM_WORDS)  index of the first mismatching word; valid when error=1
- mem_clk  out  1  equals clk
- mem_we  out  1  write enable, registered
- mem_addr  out  16  word address, registered
- mem_write_data  out  32  write data, registered
- mem_read_data  in  32  read data; valid one cycle after the address is presented

## Operation
- The state machine has four states: IDLE, WRITE, VERIFY, DONE.
- IDLE
  - On start=1: copy words into an internal buffer, latch output_addr into base, clear idx, error and err_index.
  - Then go to WRITE.
- WRITE
  - Each cycle drive mem_we=1, mem_addr=base+idx, mem_write_data=buf[idx].
  - idx increments every cycle.
  - After idx=NUM_WORDS-1: go to VERIFY if VERIFY=1, else to DONE.
- VERIFY
  - Drive mem_we=0 and mem_addr=base+idx for idx=0..NUM_WORDS-1.
  - A one-cycle delayed index (cmp_idx, cmp_valid) tracks which read data is arriving.
  - When cmp_valid=1 and mem_read_data≠buf[cmp_idx], and error is still 0: set error=1 and err_index=cmp_idx.
  - Only the first mismatch is recorded.
  - Leave VERIFY once the last compare completes.
- DONE
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Address arithmetic is modulo 2^16. base+idx wraps past 16'hFFFF to 16'h0000 with no other side effect.
- start is ignored whenever the block is not in IDLE, including the DONE cycle.
- Changes on words or output_addr after capture have no effect on the job in progress.
- Reset (synchronous)
  - Forces state=IDLE, mem_we=0, mem_addr=0, mem_write_data=0, busy=0, done=0, error=0, err_index=0, idx=0.
  - Applies even mid-job: a partly written block is abandoned, and mem_we is low from the first cycle after the reset edge.
- reset and start high in the same cycle: reset wins, and the start is lost.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- busy rises in cycle 1.
- Write k (k=0..N-1) is presented in cycle k+1 and committed at the end of that cycle.
- VERIFY=0: done pulses in cycle N+1, and busy is low in that cycle.
- VERIFY=1:
  - Read address k is presented in cycle N+1+k.
  - Its data is compared in cycle N+2+k.
  - done pulses in cycle 2N+2.
- For NUM_WORDS=16: done in cycle 17 (VERIFY=0) or cycle 34 (VERIFY=1).
- error and err_index are final by the done cycle and hold until the next accepted start or reset.
- Back-to-back jobs: a start in the cycle after done is accepted.

## Structure
- The shared package bitcoin_pkg holds:
  - the writer_state_t enum (IDLE, WRITE, VERIFY, DONE)
  - MEM_AW=16 and WORD_W=32, which the fetch logic uses as well.
- Single module with no sub-module. The buffer is a register array.
- The readback comparator is inline: one 32-bit compare plus the delayed index pipeline.

## Test plan
- N=16, VERIFY=0, base=16'h0100, words[k]=32'hA5A50000+k, start in cycle 0:
  - writes to 0x0100..0x010F with the matching data in cycles 1..16
  - done in cycle 17
  - memory model contents match.
- N=16, VERIFY=1, same data, ideal memory: no writes after cycle 16, done in cycle 34, error=0.
- VERIFY=1, memory model forces bit 0 stuck at 1 at addresses 0x0103 and 0x0107: error=1, err_index=3 at done.
- Wrap case, base=16'hFFFC, N=8: writes hit 0xFFFC..0xFFFF and then 0x0000..0x0003.
- Reset mid-job and start while busy:
  - Assert reset in cycle 5: mem_we=0 from cycle 6, all outputs at reset values, no done pulse.
  - A start pulsed in cycle 3 of a running job is ignored, and exactly one done results.
- Back-to-back jobs: second start the cycle after done, with new base 0x0200 and different data. The second job runs fully, and error from the first job is cleared.
